// File: rtl/gamepad_scanner.sv
// Polls an 8-button serial gamepad (latch/clock/data shift register), debounces every
// button and emits one-cycle run-control pulses on debounced presses.
module gamepad_scanner #(
    parameter int CLK_DIV        = 6000,
    parameter int POLL_CYCLES    = 100000,
    parameter int N_BUTTONS      = 8,
    parameter int DEBOUNCE_POLLS = 3,
    parameter int RESET_BIT      = 2,
    parameter int MODE_BIT       = 3,
    parameter int STEP_BIT       = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pad_data,
    output logic                 pad_latch,
    output logic                 pad_clk,
    output logic [N_BUTTONS-1:0] buttons,
    output logic                 btn_reset,
    output logic                 btn_mode,
    output logic                 btn_step,
    output logic                 scan_done
);

    localparam int MAX_CNT = (POLL_CYCLES > 2 * CLK_DIV) ? POLL_CYCLES : 2 * CLK_DIV;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = $clog2(N_BUTTONS);

    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BUTTONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [3:0]       DB_LAST    = 4'(DEBOUNCE_POLLS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                 state_r;
    logic [CNT_W-1:0]           cnt_r;
    logic [IDX_W-1:0]           idx_r;
    logic                       high_r;
    logic [1:0]                 sync_r;
    logic                       raw_bit_s;
    logic [N_BUTTONS-1:0]       raw_r;
    logic [N_BUTTONS-1:0]       buttons_r;
    logic [N_BUTTONS-1:0][3:0]  db_cnt_r;
    logic [N_BUTTONS-1:0]       btn_next_s;
    logic [N_BUTTONS-1:0][3:0]  db_cnt_next_s;
    logic                       pad_latch_r;
    logic                       pad_clk_r;
    logic                       btn_reset_r;
    logic                       btn_mode_r;
    logic                       btn_step_r;
    logic                       scan_done_r;

    // Two-flop synchroniser for the asynchronous, active-low pad data line
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], pad_data};
        end
    end

    assign raw_bit_s = ~sync_r[1];

    // Per-button debounce: a differing sample must persist DEBOUNCE_POLLS scans to flip the level
    always_comb begin
        btn_next_s    = buttons_r;
        db_cnt_next_s = db_cnt_r;
        for (int b = 0; b < N_BUTTONS; b++) begin
            if (raw_r[b] == buttons_r[b]) begin
                db_cnt_next_s[b] = 4'd0;
            end else if (db_cnt_r[b] == DB_LAST) begin
                btn_next_s[b]    = ~buttons_r[b];
                db_cnt_next_s[b] = 4'd0;
            end else begin
                db_cnt_next_s[b] = db_cnt_r[b] + 4'd1;
            end
        end
    end

    // Scan sequencer: idle poll, latch strobe, bit shifting, then debounce commit
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            high_r      <= 1'b0;
            raw_r       <= {N_BUTTONS{1'b0}};
            buttons_r   <= {N_BUTTONS{1'b0}};
            db_cnt_r    <= {(N_BUTTONS*4){1'b0}};
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b0;
            btn_reset_r <= 1'b0;
            btn_mode_r  <= 1'b0;
            btn_step_r  <= 1'b0;
            scan_done_r <= 1'b0;
        end else begin
            btn_reset_r <= 1'b0;
            btn_mode_r  <= 1'b0;
            btn_step_r  <= 1'b0;
            scan_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cnt_r == POLL_LAST) begin
                        state_r     <= ST_LATCH;
                        cnt_r       <= {CNT_W{1'b0}};
                        pad_latch_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_LATCH: begin
                    if (cnt_r == LATCH_LAST) begin
                        state_r     <= ST_SHIFT;
                        cnt_r       <= {CNT_W{1'b0}};
                        idx_r       <= {IDX_W{1'b0}};
                        high_r      <= 1'b0;
                        pad_latch_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != DIV_LAST) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (high_r) begin
                            high_r    <= 1'b0;
                            pad_clk_r <= 1'b0;
                            idx_r     <= idx_r + IDX_ONE;
                        end else begin
                            // Sample on the last low cycle; the final bit has no high phase
                            raw_r[idx_r] <= raw_bit_s;
                            if (idx_r == IDX_LAST) begin
                                state_r <= ST_DONE;
                            end else begin
                                high_r    <= 1'b1;
                                pad_clk_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    buttons_r   <= btn_next_s;
                    db_cnt_r    <= db_cnt_next_s;
                    scan_done_r <= 1'b1;
                    btn_reset_r <= btn_next_s[RESET_BIT] & ~buttons_r[RESET_BIT];
                    btn_mode_r  <= btn_next_s[MODE_BIT] & ~buttons_r[MODE_BIT];
                    btn_step_r  <= btn_next_s[STEP_BIT] & ~buttons_r[STEP_BIT];
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    high_r      <= 1'b0;
                    pad_latch_r <= 1'b0;
                    pad_clk_r   <= 1'b0;
                end
            endcase
        end
    end

    assign pad_latch = pad_latch_r;
    assign pad_clk   = pad_clk_r;
    assign buttons   = buttons_r;
    assign btn_reset = btn_reset_r;
    assign btn_mode  = btn_mode_r;
    assign btn_step  = btn_step_r;
    assign scan_done = scan_done_r;

endmodule

// File: tb/tb_gamepad_scanner.sv
// Directed bench for gamepad_scanner with a behavioural shift-register pad model.
module tb_gamepad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic       btn_reset;
    logic       btn_mode;
    logic       btn_step;
    logic       scan_done;

    int tests = 0;
    int failures = 0;

    logic [7:0] pad_value = 8'hFF;
    logic [7:0] pad_sr = 8'hFF;
    logic       pad_clk_d = 1'b0;
    logic       mon_clk_d = 1'b0;
    int         rises = 0;
    int         step_cnt = 0;
    int         mode_cnt = 0;
    int         reset_cnt = 0;

    gamepad_scanner #(
        .CLK_DIV(4), .POLL_CYCLES(16), .N_BUTTONS(8), .DEBOUNCE_POLLS(2),
        .RESET_BIT(2), .MODE_BIT(3), .STEP_BIT(0)
    ) dut (
        .clock(clock), .reset(reset), .pad_data(pad_data), .pad_latch(pad_latch),
        .pad_clk(pad_clk), .buttons(buttons), .btn_reset(btn_reset), .btn_mode(btn_mode),
        .btn_step(btn_step), .scan_done(scan_done)
    );

    always #5 clock = ~clock;

    // Pad: parallel load while latched, shift towards bit 0 on each pad_clk rise
    always @(posedge clock) begin
        if (pad_latch) pad_sr <= pad_value;
        else if (pad_clk && !pad_clk_d) pad_sr <= {1'b1, pad_sr[7:1]};
        pad_clk_d <= pad_clk;
    end
    assign pad_data = pad_sr[0];

    // Event counters sampled away from the active edge
    always @(negedge clock) begin
        if (pad_clk && !mon_clk_d) rises <= rises + 1;
        mon_clk_d <= pad_clk;
        if (btn_step)  step_cnt  <= step_cnt + 1;
        if (btn_mode)  mode_cnt  <= mode_cnt + 1;
        if (btn_reset) reset_cnt <= reset_cnt + 1;
    end

    task automatic wait_scan();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (scan_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++; failures++;
            $display("FAIL scan_timeout: no scan_done within 300 cycles");
        end
    endtask

    task automatic test_reset();
        int t0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) @(negedge clock);
            tests++;
            if (k < 16) begin
                if ({pad_latch, pad_clk, buttons, btn_reset, btn_mode, btn_step, scan_done} !== 14'd0) begin
                    failures++;
                    $display("FAIL reset_idle cycle %0d: outputs=%b required all 0", k,
                             {pad_latch, pad_clk, buttons, btn_reset, btn_mode, btn_step, scan_done});
                end
            end else begin
                if (pad_latch !== (k < 24 ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL latch_window cycle %0d: pad_latch=%b required %b", k, pad_latch, (k < 24));
                end
            end
        end
        wait_scan();
        t0 = rises;
        tests++;
        if (rises - t0 !== 0) failures++;
        begin
            int c0, c1;
            c0 = 0; c1 = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock);
                c1++;
                if (scan_done === 1'b1) break;
            end
            c0 = c1;
            tests++;
            if (c0 !== 85) begin
                failures++;
                $display("FAIL scan_period: got %0d cycles required 85", c0);
            end
        end
    endtask

    task automatic test_two_buttons();
        int s0, m0, r0;
        s0 = step_cnt; m0 = mode_cnt; r0 = reset_cnt;
        pad_value = 8'hF6;
        wait_scan();
        tests++;
        if (buttons !== 8'h00 || btn_step !== 1'b0 || btn_mode !== 1'b0) begin
            failures++;
            $display("FAIL scan1_quiet: buttons=%h step=%b mode=%b required 00/0/0", buttons, btn_step, btn_mode);
        end
        wait_scan();
        tests++;
        if (buttons !== 8'h09) begin
            failures++;
            $display("FAIL scan2_buttons: got %h required 09", buttons);
        end
        tests++;
        if (btn_step !== 1'b1 || btn_mode !== 1'b1 || btn_reset !== 1'b0) begin
            failures++;
            $display("FAIL scan2_pulses: step=%b mode=%b reset=%b required 1/1/0", btn_step, btn_mode, btn_reset);
        end
        @(negedge clock);
        tests++;
        if (step_cnt - s0 !== 1 || mode_cnt - m0 !== 1 || reset_cnt - r0 !== 0) begin
            failures++;
            $display("FAIL scan2_counts: step=%0d mode=%0d reset=%0d required 1/1/0",
                     step_cnt - s0, mode_cnt - m0, reset_cnt - r0);
        end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = step_cnt;
        pad_value = 8'hFF;
        wait_scan();
        wait_scan();
        tests++;
        if (buttons !== 8'h00) begin
            failures++;
            $display("FAIL release_all: buttons=%h required 00", buttons);
        end
        pad_value = 8'hFE;
        wait_scan();
        pad_value = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            wait_scan();
            tests++;
            if (buttons[0] !== 1'b0) begin
                failures++;
                $display("FAIL glitch_level scan %0d: buttons[0]=%b required 0", i, buttons[0]);
            end
        end
        @(negedge clock);
        tests++;
        if (step_cnt - s0 !== 0) begin
            failures++;
            $display("FAIL glitch_pulse: step pulses=%0d required 0", step_cnt - s0);
        end
    endtask

    task automatic test_hold_repress();
        int s0, r0;
        s0 = step_cnt;
        pad_value = 8'hFE;
        for (int i = 0; i < 10; i++) begin
            r0 = rises;
            wait_scan();
            tests++;
            if (rises - r0 !== 7) begin
                failures++;
                $display("FAIL clk_rises scan %0d: got %0d required 7", i, rises - r0);
            end
        end
        @(negedge clock);
        tests++;
        if (step_cnt - s0 !== 1 || buttons !== 8'h01) begin
            failures++;
            $display("FAIL hold_once: pulses=%0d buttons=%h required 1/01", step_cnt - s0, buttons);
        end
        pad_value = 8'hFF;
        wait_scan();
        wait_scan();
        tests++;
        if (buttons !== 8'h00) begin
            failures++;
            $display("FAIL hold_release: buttons=%h required 00", buttons);
        end
        pad_value = 8'hFE;
        wait_scan();
        wait_scan();
        @(negedge clock);
        tests++;
        if (step_cnt - s0 !== 2 || buttons !== 8'h01) begin
            failures++;
            $display("FAIL repress: pulses=%0d buttons=%h required 2/01", step_cnt - s0, buttons);
        end
    endtask

    task automatic test_select();
        int r0;
        r0 = reset_cnt;
        pad_value = 8'hFB;
        wait_scan();
        tests++;
        if (btn_reset !== 1'b0) begin
            failures++;
            $display("FAIL select_early: btn_reset=%b required 0", btn_reset);
        end
        wait_scan();
        tests++;
        if (btn_reset !== 1'b1 || buttons !== 8'h04 || btn_step !== 1'b0) begin
            failures++;
            $display("FAIL select_pulse: btn_reset=%b buttons=%h step=%b required 1/04/0", btn_reset, buttons, btn_step);
        end
        @(negedge clock);
        tests++;
        if (btn_reset !== 1'b0 || reset_cnt - r0 !== 1) begin
            failures++;
            $display("FAIL select_width: btn_reset=%b pulses=%0d required 0/1", btn_reset, reset_cnt - r0);
        end
    endtask

    task automatic test_reset_abort();
        int seen, k;
        bit prev;
        for (int i = 0; i < 200 && pad_latch !== 1'b1; i++) @(negedge clock);
        for (int i = 0; i < 50 && pad_latch !== 1'b0; i++) @(negedge clock);
        seen = 0; prev = pad_clk;
        for (int i = 0; i < 100 && seen < 5; i++) begin
            @(negedge clock);
            if (pad_clk && !prev) seen++;
            prev = pad_clk;
        end
        tests++;
        if (seen !== 5 || pad_clk !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: rises=%0d pad_clk=%b required 5/1", seen, pad_clk);
        end
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (pad_clk !== 1'b0 || pad_latch !== 1'b0 || buttons !== 8'h00 || scan_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs: clk=%b latch=%b buttons=%h done=%b required 0/0/00/0",
                     pad_clk, pad_latch, buttons, scan_done);
        end
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            k++;
            if (pad_latch === 1'b1) break;
        end
        tests++;
        if (k !== 16) begin
            failures++;
            $display("FAIL abort_restart: latch after %0d cycles required 16", k);
        end
        wait_scan();
        tests++;
        if (btn_reset !== 1'b0 || buttons !== 8'h00) begin
            failures++;
            $display("FAIL held_scan1: btn_reset=%b buttons=%h required 0/00", btn_reset, buttons);
        end
        wait_scan();
        tests++;
        if (btn_reset !== 1'b1 || buttons !== 8'h04) begin
            failures++;
            $display("FAIL held_scan2: btn_reset=%b buttons=%h required 1/04", btn_reset, buttons);
        end
    endtask

    initial begin
        test_reset();
        test_two_buttons();
        test_glitch();
        test_hold_repress();
        test_select();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
